// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: data register (tx/rx byte) and status register.
// Independent TX and RX state machines with a 2-flop rx synchronizer.
module uart_mmio #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        CE_UART,
    input  logic        CE_SR,
    input  logic        UART_WR,
    input  logic        UART_RD,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        tx,
    input  logic        rx
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic w_wr_data, w_rd_data, w_rd_sr, w_tx_busy;
    logic w_unused;

    assign w_wr_data = CE_UART & UART_WR;
    assign w_rd_data = CE_UART & UART_RD;
    assign w_rd_sr   = CE_SR & UART_RD;
    assign w_unused  = ^WriteData[31:8];

    state_t        r_tx_st, w_tx_st_n;
    logic [CW-1:0] r_tx_cnt, w_tx_cnt_n;
    logic [2:0]    r_tx_bit, w_tx_bit_n;
    logic [7:0]    r_tx_sh, w_tx_sh_n;
    logic          r_tx, w_tx_n;

    assign w_tx_busy = (r_tx_st != S_IDLE);
    assign tx        = r_tx;

    always_comb begin
        w_tx_st_n  = r_tx_st;
        w_tx_cnt_n = r_tx_cnt + 1'b1;
        w_tx_bit_n = r_tx_bit;
        w_tx_sh_n  = r_tx_sh;
        w_tx_n     = r_tx;
        unique case (r_tx_st)
            S_IDLE: begin
                w_tx_cnt_n = '0;
                w_tx_n     = 1'b1;
                if (w_wr_data) begin
                    w_tx_st_n = S_START;
                    w_tx_sh_n = WriteData[7:0];
                    w_tx_n    = 1'b0;
                end
            end
            S_START: begin
                if (r_tx_cnt == LAST) begin
                    w_tx_cnt_n = '0;
                    w_tx_st_n  = S_DATA;
                    w_tx_bit_n = '0;
                    w_tx_n     = r_tx_sh[0];
                end
            end
            S_DATA: begin
                if (r_tx_cnt == LAST) begin
                    w_tx_cnt_n = '0;
                    if (r_tx_bit == 3'd7) begin
                        w_tx_st_n = S_STOP;
                        w_tx_n    = 1'b1;
                    end else begin
                        w_tx_bit_n = r_tx_bit + 3'd1;
                        w_tx_sh_n  = {1'b0, r_tx_sh[7:1]};
                        w_tx_n     = r_tx_sh[1];
                    end
                end
            end
            S_STOP: begin
                if (r_tx_cnt == LAST) begin
                    w_tx_cnt_n = '0;
                    w_tx_st_n  = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_st  <= S_IDLE;
            r_tx_cnt <= '0;
            r_tx_bit <= '0;
            r_tx_sh  <= '0;
            r_tx     <= 1'b1;
        end else begin
            r_tx_st  <= w_tx_st_n;
            r_tx_cnt <= w_tx_cnt_n;
            r_tx_bit <= w_tx_bit_n;
            r_tx_sh  <= w_tx_sh_n;
            r_tx     <= w_tx_n;
        end
    end

    logic          r_rx_s1, r_rx_s2, r_rx_prev;
    state_t        r_rx_st, w_rx_st_n;
    logic [CW-1:0] r_rx_cnt, w_rx_cnt_n;
    logic [2:0]    r_rx_bit, w_rx_bit_n;
    logic [7:0]    r_rx_sh, w_rx_sh_n;
    logic [7:0]    r_rx_data, w_rx_data_n;
    logic          r_rx_valid, w_rx_valid_n;
    logic          r_oe, w_oe_n, r_fe, w_fe_n;

    always_comb begin
        w_rx_st_n    = r_rx_st;
        w_rx_cnt_n   = r_rx_cnt + 1'b1;
        w_rx_bit_n   = r_rx_bit;
        w_rx_sh_n    = r_rx_sh;
        w_rx_data_n  = r_rx_data;
        w_rx_valid_n = r_rx_valid & ~w_rd_data;
        w_oe_n       = r_oe & ~w_rd_sr;
        w_fe_n       = r_fe & ~w_rd_sr;
        unique case (r_rx_st)
            S_IDLE: begin
                w_rx_cnt_n = '0;
                if (r_rx_prev & ~r_rx_s2) begin
                    w_rx_st_n = S_START;
                end
            end
            S_START: begin
                if (r_rx_cnt == HALF) begin
                    w_rx_cnt_n = '0;
                    w_rx_bit_n = '0;
                    w_rx_st_n  = r_rx_s2 ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_rx_cnt == LAST) begin
                    w_rx_cnt_n = '0;
                    w_rx_sh_n  = {r_rx_s2, r_rx_sh[7:1]};
                    w_rx_bit_n = r_rx_bit + 3'd1;
                    if (r_rx_bit == 3'd7) begin
                        w_rx_st_n = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (r_rx_cnt == LAST) begin
                    w_rx_cnt_n = '0;
                    w_rx_st_n  = S_IDLE;
                    // A same-cycle data read frees the slot: load wins.
                    if (!r_rx_s2) begin
                        w_fe_n = 1'b1;
                    end else if (!r_rx_valid || w_rd_data) begin
                        w_rx_data_n  = r_rx_sh;
                        w_rx_valid_n = 1'b1;
                    end else begin
                        w_oe_n = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_st    <= S_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_sh    <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_oe       <= 1'b0;
            r_fe       <= 1'b0;
        end else begin
            r_rx_s1    <= rx;
            r_rx_s2    <= r_rx_s1;
            r_rx_prev  <= r_rx_s2;
            r_rx_st    <= w_rx_st_n;
            r_rx_cnt   <= w_rx_cnt_n;
            r_rx_bit   <= w_rx_bit_n;
            r_rx_sh    <= w_rx_sh_n;
            r_rx_data  <= w_rx_data_n;
            r_rx_valid <= w_rx_valid_n;
            r_oe       <= w_oe_n;
            r_fe       <= w_fe_n;
        end
    end

    always_comb begin
        ReadData = '0;
        if (w_rd_data) begin
            ReadData = {24'b0, r_rx_data};
        end else if (w_rd_sr) begin
            ReadData = {28'b0, r_fe, r_oe, r_rx_valid, w_tx_busy};
        end
    end
endmodule

// File: tb/tb_uart_mmio.sv
// Scoreboard bench for uart_mmio: read and tx-frame monitors pop
// expected values queued by the directed stimulus.
module tb_uart_mmio;
    localparam int CPB = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        CE_UART = 1'b0;
    logic        CE_SR = 1'b0;
    logic        UART_WR = 1'b0;
    logic        UART_RD = 1'b0;
    logic [31:0] WriteData = '0;
    logic [31:0] ReadData;
    logic        tx;
    logic        rx_drv = 1'b1;
    logic        loop = 1'b0;
    logic        rx_w;

    assign rx_w = loop ? tx : rx_drv;

    uart_mmio #(.CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .CE_UART  (CE_UART),
        .CE_SR    (CE_SR),
        .UART_WR  (UART_WR),
        .UART_RD  (UART_RD),
        .WriteData(WriteData),
        .ReadData (ReadData),
        .tx       (tx),
        .rx       (rx_w)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] v;
        int          id;
    } rd_t;

    rd_t        rd_q[$];
    int         rd_id = 0;
    logic [7:0] tx_q[$];

    task automatic push_rd(input logic [31:0] v);
        rd_t e;
        e.v = v;
        e.id = rd_id;
        rd_id++;
        rd_q.push_back(e);
    endtask

    always @(negedge clk) begin
        rd_t e;
        if (UART_RD && (CE_UART || CE_SR)) begin
            if (rd_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL read_unexpected: got 0x%08h expected none",
                         ReadData);
            end else begin
                e = rd_q.pop_front();
                chk($sformatf("read%0d", e.id), ReadData, e.v);
            end
        end
    end

    logic       prev_tx = 1'b1;
    logic [7:0] f_exp, f_got;
    int         f_mism, f_idx;
    logic       f_ab, f_eb;

    always begin
        @(negedge clk);
        if (rst_n && prev_tx && !tx) begin
            if (tx_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL tx_unexpected: got frame expected none");
                f_exp = '0;
            end else begin
                f_exp = tx_q.pop_front();
            end
            f_mism = 0;
            f_ab = 1'b0;
            f_got = '0;
            for (int k = 0; k < 10 * CPB; k++) begin
                if (k > 0) @(negedge clk);
                if (!rst_n) begin
                    f_ab = 1'b1;
                    break;
                end
                f_idx = k / CPB;
                if (f_idx == 0) f_eb = 1'b0;
                else if (f_idx == 9) f_eb = 1'b1;
                else f_eb = f_exp[f_idx-1];
                if (tx !== f_eb) f_mism++;
                if (f_idx >= 1 && f_idx <= 8 && (k % CPB) == CPB / 2)
                    f_got[f_idx-1] = tx;
            end
            if (!f_ab) begin
                chk("tx_byte", {24'b0, f_got}, {24'b0, f_exp});
                chk("tx_shape", f_mism, 0);
            end
        end
        prev_tx = tx;
    end

    task automatic wr(input logic [7:0] d);
        @(posedge clk);
        #1;
        CE_UART = 1'b1;
        UART_WR = 1'b1;
        WriteData = {24'hFFFFFF, d};
        @(posedge clk);
        #1;
        CE_UART = 1'b0;
        UART_WR = 1'b0;
    endtask

    task automatic rd(input logic sr, input logic [31:0] v);
        @(posedge clk);
        #1;
        CE_SR = sr;
        CE_UART = !sr;
        UART_RD = 1'b1;
        push_rd(v);
        @(posedge clk);
        #1;
        CE_SR = 1'b0;
        CE_UART = 1'b0;
        UART_RD = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stopb);
        @(posedge clk);
        #1 rx_drv = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(posedge clk);
            #1 rx_drv = b[i];
        end
        repeat (CPB) @(posedge clk);
        #1 rx_drv = stopb;
        repeat (CPB) @(posedge clk);
        #1 rx_drv = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        rd(1'b1, 32'h0);
        chk("tx_idle", {31'b0, tx}, 32'h1);

        tx_q.push_back(8'hA5);
        wr(8'hA5);
        chk("tx_start_low", {31'b0, tx}, 32'h0);
        for (int c = 0; c <= 10 * CPB; c++) begin
            if (c == 5 * CPB) begin
                CE_SR = 1'b0;
                UART_RD = 1'b0;
                CE_UART = 1'b1;
                UART_WR = 1'b1;
                WriteData = 32'h3C;
            end else begin
                CE_UART = 1'b0;
                UART_WR = 1'b0;
                CE_SR = 1'b1;
                UART_RD = 1'b1;
                push_rd((c < 10 * CPB) ? 32'h1 : 32'h0);
            end
            @(posedge clk);
            #1;
        end
        CE_SR = 1'b0;
        UART_RD = 1'b0;
        repeat (20) @(posedge clk);

        send_rx(8'h5A, 1'b1);
        @(posedge clk);
        #1 rx_drv = 1'b0;
        repeat (3) @(posedge clk);
        #1 rx_drv = 1'b1;
        repeat (20) @(posedge clk);
        rd(1'b1, 32'h2);
        rd(1'b0, 32'h5A);
        rd(1'b1, 32'h0);

        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        rd(1'b1, 32'h6);
        rd(1'b1, 32'h2);
        rd(1'b0, 32'h11);

        send_rx(8'h33, 1'b0);
        repeat (4) @(posedge clk);
        rd(1'b1, 32'h8);
        rd(1'b1, 32'h0);

        send_rx(8'h55, 1'b1);
        fork
            send_rx(8'h44, 1'b1);
            begin
                repeat (10 * CPB - 2) @(posedge clk);
                rd(1'b0, 32'h55);
            end
        join
        rd(1'b1, 32'h2);
        rd(1'b0, 32'h44);
        rd(1'b1, 32'h0);

        loop = 1'b1;
        tx_q.push_back(8'hC3);
        wr(8'hC3);
        repeat (100) @(posedge clk);
        rd(1'b1, 32'h2);
        rd(1'b0, 32'hC3);

        tx_q.push_back(8'hF0);
        wr(8'hF0);
        repeat (29) @(posedge clk);
        #2 chk("tx_mid_frame", {31'b0, tx}, 32'h0);
        #1 rst_n = 1'b0;
        #1 chk("tx_async_reset", {31'b0, tx}, 32'h1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        rd(1'b1, 32'h0);
        repeat (20) @(posedge clk);
        rd(1'b1, 32'h0);
        rd(1'b0, 32'h0);

        repeat (10) @(posedge clk);
        chk("rd_queue_empty", rd_q.size(), 0);
        chk("tx_queue_empty", tx_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_mmio.md
Name: uart_mmio

Overview:
- Memory-mapped 8N1 UART peripheral; the responder side of the CPU data bus for the UART window.
- Data register at 0x3000 (write = transmit byte, read = received byte); status register at 0x3004.
- Consumes the chip-enable and read/write strobes from the address decoder and the CPU store data. Returns read data to the CPU load mux and drives the serial tx/rx pins.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200); legal range ≥ 4, even.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- CE_UART  in  1  data-register select from address decoder
- CE_SR  in  1  status-register select from address decoder
- UART_WR  in  1  write strobe, one access per asserted cycle
- UART_RD  in  1  read strobe, one access per asserted cycle
- WriteData  in  32  CPU store data; only [7:0] used
- ReadData  out  32  CPU load data, combinational from registers
- tx  out  1  serial output, idle high
- rx  in  1  serial input, asynchronous to clk

Behaviour:
- Access qualification:
  - data write = CE_UART & UART_WR
  - data read = CE_UART & UART_RD
  - status read = CE_SR & UART_RD
  - CE_UART without a strobe (RAM range) has no effect.
- ReadData is combinational:
  - data read: {24'b0, rx_data}
  - status read: {28'b0, FE, OE, rx_valid, tx_busy}
  - otherwise 0
  - Read side effects take effect at the closing clock edge.
- Reset values: tx=1, tx_busy=0, rx_valid=0, OE=0, FE=0, rx_data=0x00, both FSMs IDLE, all counters 0.
- TX FSM (IDLE → START → DATA → STOP → IDLE):
  - A data write in IDLE latches WriteData[7:0] and sets tx_busy on the next edge.
  - tx goes low in the first cycle after the write.
  - Each bit is held exactly CLKS_PER_BIT cycles: start(0), d0..d7 LSB first, stop(1).
  - tx_busy stays high for exactly 10*CLKS_PER_BIT cycles, then clears. A new write accepted in the cycle tx_busy reads 0 starts back-to-back with no idle gap.
  - A data write while tx_busy=1 is ignored; the in-flight frame is unaffected.
- RX path:
  - rx passes a 2-flop synchronizer (sync reset value 1); all decisions use the synchronized signal.
  - IDLE: a 1→0 transition enters START.
  - START: sample at CLKS_PER_BIT/2. If high, it was a glitch: return to IDLE with no flags. If low, enter DATA.
  - DATA: sample every CLKS_PER_BIT at mid-bit, 8 bits, LSB first into a shift register.
  - STOP: sample at mid-bit.
    - Stop=1, rx_valid=0: load rx_data, set rx_valid.
    - Stop=1, rx_valid=1: drop the new byte, keep rx_data, set OE.
    - Stop=0: drop the byte, set FE; rx_data and rx_valid unchanged.
  - After the stop sample, return to IDLE, which re-arms falling-edge detection. A continuous-low line after a framing error does not restart until rx returns high.
- Flag clearing:
  - A data read clears rx_valid.
  - A status read clears OE and FE (sticky until read). tx_busy and rx_valid are not cleared by a status read.
- Simultaneous events:
  - Data read in the same cycle a byte completes: new byte loaded, rx_valid stays 1, no OE (set wins over clear).
  - Status read in the same cycle OE/FE is set: flag stays 1; ReadData shows the pre-edge value.
  - Data write and data read in the same cycle: both performed independently.
- Reset asserted mid-frame aborts both FSMs immediately: tx=1 asynchronously, partial RX byte discarded, no flags set.
- TX and RX are fully independent; loopback (tx tied to rx) must work.

Test Plan (CLKS_PER_BIT=8):
- Reset then status read → ReadData=0x00000000; tx=1.
- Data write 0x000000A5 → tx low from next cycle for 8 cycles, then bits 1,0,1,0,0,1,0,1 at 8 cycles each, stop high. Status bit0=1 for exactly 80 cycles. A second write 0x3C at cycle 40 is ignored (frame unchanged).
- Drive rx frame 0x5A → rx_valid=1 about 76 cycles after the start edge. Data read returns 0x0000005A, the following status read shows bit1=0. A 3-cycle low glitch on rx sets no flags and leaves rx_valid unchanged.
- Two frames 0x11 then 0x22 without an intervening read → rx_data=0x11, status=0x6 (OE|rx_valid). Status read clears OE, the next status read returns 0x2.
- Frame 0x33 with stop bit driven 0 → status bit3=1, rx_valid=0. Data read issued on the exact cycle a frame 0x44 completes → ReadData shows the old byte, rx_valid remains 1, rx_data=0x44, OE=0.
- Loopback tx→rx with write 0xC3 → rx_data=0xC3, rx_valid=1. Assert rst_n low at cycle 30 of a second frame → tx=1 immediately, all status bits 0 after release.
